// File: rtl/bmem_arbiter.sv
// Two-client arbiter for the shared burst-memory port: one owner per transaction,
// round-robin on ties, read beats routed only to the client that issued the read.
module bmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic              c0_read,
  input  logic              c0_write,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_ready,
  output logic [ADDR_W-1:0] c0_raddr,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_rvalid,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic              c1_read,
  input  logic              c1_write,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_ready,
  output logic [ADDR_W-1:0] c1_raddr,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_rvalid,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [DATA_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [DATA_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid,
  output logic [1:0]        dbg_state
);

  // Handshake: a request or write beat transfers on a cycle where the arbiter
  // drives bmem_read/bmem_write and bmem_ready is 1; that same cycle the owner
  // sees cN_ready. Read beats have no back-pressure: cN_rvalid is a one-cycle strobe.

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RISSUE = 2'd2,
    RWAIT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_owner_q, last_owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            req0, req1, winner, winner_wr;
  logic            accept, rv_fwd;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    req0         = c0_read | c0_write;
    req1         = c1_read | c1_write;
    // On a tie the client that did not win last time goes next.
    winner       = (req0 & req1) ? ~last_owner_q : req1;
    winner_wr    = winner ? c1_write : c0_write;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 | req1) begin
          owner_d      = winner;
          last_owner_d = winner;
          state_d      = winner_wr ? WBURST : RISSUE;
        end
      end
      WBURST: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = IDLE;
        end
      end
      RISSUE: begin
        // A response beat arriving alongside request acceptance still counts.
        if (bmem_rvalid) cnt_d = cnt_q + 1'b1;
        if (bmem_ready) state_d = RWAIT;
      end
      RWAIT: begin
        if (bmem_rvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  assign own_addr   = owner_q ? c1_addr : c0_addr;
  assign own_wdata  = owner_q ? c1_wdata : c0_wdata;

  assign bmem_addr  = (state_q == IDLE) ? '0 : own_addr;
  assign bmem_wdata = (state_q == WBURST) ? own_wdata : '0;
  assign bmem_write = (state_q == WBURST);
  assign bmem_read  = (state_q == RISSUE);

  assign accept     = ((state_q == WBURST) || (state_q == RISSUE)) & bmem_ready;
  assign c0_ready   = accept & ~owner_q;
  assign c1_ready   = accept & owner_q;

  // Beats seen outside a read transaction (e.g. stragglers after reset) are dropped.
  assign rv_fwd     = ((state_q == RISSUE) || (state_q == RWAIT)) & bmem_rvalid;
  assign c0_rvalid  = rv_fwd & ~owner_q;
  assign c1_rvalid  = rv_fwd & owner_q;

  assign c0_raddr   = bmem_raddr;
  assign c1_raddr   = bmem_raddr;
  assign c0_rdata   = bmem_rdata;
  assign c1_rdata   = bmem_rdata;

  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Bench for bmem_arbiter: client drivers, a burst-memory model, and a scoreboard
// that pairs every bmem-side beat and client read beat with what the stimulus expects.
module tb_bmem_arbiter;

  localparam int BL  = 4;
  localparam int TMO = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] c_addr  [2];
  logic        c_read  [2];
  logic        c_write [2];
  logic [63:0] c_wdata [2];

  logic        c0_ready, c1_ready, c0_rvalid, c1_rvalid;
  logic [31:0] c0_raddr, c1_raddr;
  logic [63:0] c0_rdata, c1_rdata;
  logic [31:0] bmem_addr;
  logic        bmem_read, bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready  = 1'b0;
  logic [31:0] bmem_raddr  = '0;
  logic [63:0] bmem_rdata  = '0;
  logic        bmem_rvalid = 1'b0;
  logic [1:0]  dbg_state;

  bmem_arbiter #(.ADDR_W(32), .DATA_W(64), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .c0_addr(c_addr[0]), .c0_read(c_read[0]), .c0_write(c_write[0]), .c0_wdata(c_wdata[0]),
    .c0_ready(c0_ready), .c0_raddr(c0_raddr), .c0_rdata(c0_rdata), .c0_rvalid(c0_rvalid),
    .c1_addr(c_addr[1]), .c1_read(c_read[1]), .c1_write(c_write[1]), .c1_wdata(c_wdata[1]),
    .c1_ready(c1_ready), .c1_raddr(c1_raddr), .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // Expected responses: {addr, data} per write beat, {raddr, rdata} per read beat.
  logic [95:0] exp_wr_q0[$];
  logic [95:0] exp_wr_q1[$];
  logic [95:0] exp_rd_q0[$];
  logic [95:0] exp_rd_q1[$];
  logic        exp_grant_q[$];

  // Memory model state
  logic [31:0] mem_pend_q[$];
  int          mem_beat = 0;
  int          mem_cur  = 0;
  int          rdy_mode = 1;
  int          rdy_pct  = 100;
  int          rv_pct   = 100;
  bit          tog      = 1'b1;
  bit          drop_mode = 1'b0;
  int          wr_beat_cnt = 0;
  logic        mon_id;

  function automatic logic [63:0] mem_word(input logic [31:0] a, input int b);
    return {a ^ 32'h5A5A_0000, 32'(b) + 32'hD000_0000};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not allowed here", name);
  endtask

  task automatic grant_event(input logic id);
    if (exp_grant_q.size() > 0) check("grant_order", id, exp_grant_q.pop_front());
  endtask

  function automatic logic ready_of(input int c);
    return (c == 0) ? c0_ready : c1_ready;
  endfunction

  // Memory controller model: drives ready and read beats after the clients settle.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1:       bmem_ready = 1'b1;
      2:       begin bmem_ready = tog; tog = ~tog; end
      default: bmem_ready = ($urandom_range(99) < rdy_pct);
    endcase
    if (bmem_read && bmem_ready) mem_pend_q.push_back(bmem_addr);
    if (mem_pend_q.size() > 0 && $urandom_range(99) < rv_pct) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = mem_pend_q[0];
      bmem_rdata  = mem_word(mem_pend_q[0], mem_beat);
      mem_cur     = mem_beat;
      mem_beat++;
      if (mem_beat == BL) begin
        mem_beat = 0;
        void'(mem_pend_q.pop_front());
      end
    end else begin
      bmem_rvalid = 1'b0;
      bmem_rdata  = {$urandom, $urandom};
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (c0_rvalid && c1_rvalid) fail_now("rvalid_both_clients");
      if (drop_mode && bmem_rvalid) check("stray_beat_dropped", {c0_rvalid, c1_rvalid}, 2'b00);
      if (c0_rvalid) begin
        if (exp_rd_q0.size() == 0) fail_now("c0_unexpected_rvalid");
        else check("c0_read_beat", {c0_raddr, c0_rdata}, exp_rd_q0.pop_front());
      end
      if (c1_rvalid) begin
        if (exp_rd_q1.size() == 0) fail_now("c1_unexpected_rvalid");
        else check("c1_read_beat", {c1_raddr, c1_rdata}, exp_rd_q1.pop_front());
      end
      if (bmem_write && bmem_ready) begin
        mon_id = bmem_addr[31];
        check("write_ready", {c0_ready, c1_ready}, mon_id ? 2'b01 : 2'b10);
        if (mon_id) begin
          if (exp_wr_q1.size() == 0) fail_now("c1_unexpected_write");
          else check("c1_write_beat", {bmem_addr, bmem_wdata}, exp_wr_q1.pop_front());
        end else begin
          if (exp_wr_q0.size() == 0) fail_now("c0_unexpected_write");
          else check("c0_write_beat", {bmem_addr, bmem_wdata}, exp_wr_q0.pop_front());
        end
        if (wr_beat_cnt == 0) grant_event(mon_id);
        wr_beat_cnt = (wr_beat_cnt + 1) % BL;
      end
      if (bmem_read && bmem_ready) begin
        mon_id = bmem_addr[31];
        check("read_ready", {c0_ready, c1_ready}, mon_id ? 2'b01 : 2'b10);
        grant_event(mon_id);
      end
    end
  end

  // Drivers are called at posedge+1 and return at posedge+1.
  task automatic drive_write(input int c, input logic [31:0] a, input logic [63:0] d0,
                             input bit also_read);
    int beats = 0;
    int cyc   = 0;
    c_addr[c]  = a;
    c_wdata[c] = d0;
    c_write[c] = 1'b1;
    c_read[c]  = also_read;
    for (int k = 0; k < BL; k++) begin
      if (c == 0) exp_wr_q0.push_back({a, d0 + 64'(k)});
      else        exp_wr_q1.push_back({a, d0 + 64'(k)});
    end
    while (beats < BL) begin
      @(negedge clk);
      if (ready_of(c)) begin
        beats++;
        @(posedge clk); #1;
        if (beats == BL) begin
          c_write[c] = 1'b0;
          c_read[c]  = 1'b0;
        end else begin
          c_wdata[c] = d0 + 64'(beats);
        end
      end else if (++cyc > TMO) begin
        fail_now("write_timeout");
        c_write[c] = 1'b0;
        c_read[c]  = 1'b0;
        @(posedge clk); #1;
        break;
      end
    end
  endtask

  task automatic drive_read(input int c, input logic [31:0] a);
    int cyc = 0;
    c_addr[c] = a;
    c_read[c] = 1'b1;
    for (int k = 0; k < BL; k++) begin
      if (c == 0) exp_rd_q0.push_back({a, mem_word(a, k)});
      else        exp_rd_q1.push_back({a, mem_word(a, k)});
    end
    forever begin
      @(negedge clk);
      if (ready_of(c)) break;
      if (++cyc > TMO) begin
        fail_now("read_timeout");
        break;
      end
    end
    @(posedge clk); #1;
    c_read[c] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((exp_rd_q0.size() + exp_rd_q1.size() + exp_wr_q0.size() + exp_wr_q1.size()
            + mem_pend_q.size()) != 0 && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= TMO) fail_now(name);
    @(posedge clk); #1;
    check({name, "_idle"}, dbg_state, 2'd0);
  endtask

  task automatic clear_all();
    for (int c = 0; c < 2; c++) begin
      c_addr[c] = '0; c_read[c] = 1'b0; c_write[c] = 1'b0; c_wdata[c] = '0;
    end
    exp_wr_q0.delete(); exp_wr_q1.delete(); exp_rd_q0.delete(); exp_rd_q1.delete();
    exp_grant_q.delete(); mem_pend_q.delete();
    mem_beat = 0; wr_beat_cnt = 0;
  endtask

  task automatic rand_client(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      logic [63:0] d;
      int gap;
      a = $urandom; a[31] = c[0]; a[3:0] = 4'h0;
      d = {$urandom, $urandom};
      gap = $urandom_range(3);
      repeat (gap) begin @(posedge clk); #1; end
      if ($urandom_range(1) == 1) drive_write(c, a, d, 1'($urandom_range(1)));
      else drive_read(c, a);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int seen;
    clear_all();
    #1 rst = 1'b0;
    #1 check("reset_outputs",
             {bmem_read, bmem_write, bmem_addr, bmem_wdata, c0_ready, c1_ready,
              c0_rvalid, c1_rvalid, dbg_state}, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Simultaneous reads straight after reset: client 0 first, then client 1.
    rdy_mode = 1; rv_pct = 100;
    exp_grant_q.push_back(1'b0); exp_grant_q.push_back(1'b1);
    fork
      drive_read(0, 32'h0000_2000);
      drive_read(1, 32'h8000_2000);
    join
    wait_drain("tie_reads");

    // Single write burst with memory always ready.
    exp_grant_q.push_back(1'b0);
    fork
      drive_write(0, 32'h0000_1000, 64'hA0, 1'b0);
      begin
        @(negedge clk);
        check("wr_latency", bmem_write, 1'b0);
        for (int i = 0; i < BL; i++) begin
          @(negedge clk);
          check("wr_beat_timing", {bmem_write, c0_ready, bmem_addr, bmem_wdata},
                {1'b1, 1'b1, 32'h0000_1000, 64'hA0 + 64'(i)});
        end
        @(negedge clk);
        check("wr_back_to_idle", {dbg_state, bmem_write}, 3'b000);
      end
    join
    @(posedge clk); #1;
    wait_drain("single_write");

    // Client 1 write under a 1,0,1,0 ready pattern; client 0 read waits its turn.
    rdy_mode = 2; tog = 1'b1;
    exp_grant_q.push_back(1'b1); exp_grant_q.push_back(1'b0);
    fork
      drive_write(1, 32'h8000_3000, 64'hB0, 1'b0);
      begin
        repeat (2) begin @(posedge clk); #1; end
        drive_read(0, 32'h0000_3000);
      end
    join
    wait_drain("toggle_ready");

    // Reset pulsed in the middle of a read's response beats.
    rdy_mode = 1; rv_pct = 100;
    drive_read(0, 32'h0000_4000);
    cyc = 0;
    while (!(bmem_rvalid && mem_cur == 1) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reset_reached_beat", cyc < 50, 1'b1);
    #3 rst = 1'b0;
    #1 check("async_reset_outputs",
             {bmem_read, bmem_write, bmem_addr, bmem_wdata, c0_ready, c1_ready,
              c0_rvalid, c1_rvalid, dbg_state}, '0);
    exp_rd_q0.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    drop_mode = 1'b1;
    wait_drain("reset_drop");
    drop_mode = 1'b0;

    // Read and write asserted together: the write wins and no read is issued.
    exp_grant_q.push_back(1'b0);
    fork
      drive_write(0, 32'h0000_5000, 64'hC0, 1'b1);
      begin
        seen = 0;
        repeat (BL + 2) begin
          @(negedge clk);
          if (bmem_read) seen++;
        end
        check("rw_no_read", seen, 0);
      end
    join
    @(posedge clk); #1;
    wait_drain("read_write_both");

    // Continuous contention from reset: grants alternate 0,1,0,1.
    rst = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) exp_grant_q.push_back(1'(i % 2));
    fork
      begin
        drive_write(0, 32'h0000_6000, 64'hD0, 1'b0);
        drive_write(0, 32'h0000_6100, 64'hD8, 1'b0);
      end
      begin
        drive_write(1, 32'h8000_6000, 64'hE0, 1'b0);
        drive_write(1, 32'h8000_6100, 64'hE8, 1'b0);
      end
    join
    wait_drain("round_robin");
    check("grants_consumed", exp_grant_q.size(), 0);

    // Randomised traffic from both clients.
    rdy_mode = 0; rdy_pct = 75; rv_pct = 70;
    fork
      rand_client(0, 12);
      rand_client(1, 12);
    join
    wait_drain("random");

    check("final_queues_empty",
          exp_wr_q0.size() + exp_wr_q1.size() + exp_rd_q0.size() + exp_rd_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bmem_arbiter.md
# bmem_arbiter

Two-client arbiter that shares the single burst-memory (bmem) port of the FPGA memory controller between the out-of-order core's cache side (client 0) and the pipelined core's cache side (client 1). It grants one client at a time and holds that grant for the whole transaction: a BURST_LEN-beat write burst, or a read request plus all of its BURST_LEN response beats. Tied requests are resolved round-robin. Read responses are routed back only to the owning client.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, beat width
- BURST_LEN, 4, beats per line (power of two, ≥2)
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset (0 = in reset)
- cN_addr  in  ADDR_W  client N line address (N = 0, 1); held for the whole transaction
- cN_read  in  1  client N read request
- cN_write  in  1  client N write request; held through all beats
- cN_wdata  in  DATA_W  client N write beat; advances after each accepted beat
- cN_ready  out  1  client N beat/request accepted this cycle
- cN_raddr  out  ADDR_W  broadcast copy of bmem_raddr
- cN_rdata  out  DATA_W  broadcast copy of bmem_rdata
- cN_rvalid  out  1  read beat valid for client N
- bmem_addr  out  ADDR_W  to memory controller
- bmem_read  out  1  to memory controller
- bmem_write  out  1  to memory controller
- bmem_wdata  out  DATA_W  to memory controller
- bmem_ready  in  1  controller accepts request/beat
- bmem_raddr  in  ADDR_W  response address
- bmem_rdata  in  DATA_W  response beat
- bmem_rvalid  in  1  response beat valid

## Operation
- Registers: state {IDLE, WBURST, RISSUE, RWAIT}; owner (1 bit); last_owner (1 bit); beat counter (log2(BURST_LEN) bits).
- IDLE:
  - A client requests when it asserts read or write.
  - Only one client requesting: that client wins.
  - Both requesting: the winner is the complement of last_owner.
  - The winner is registered into owner and last_owner.
  - Next state is WBURST if the winner asserts write (write has priority when a client asserts both read and write), otherwise RISSUE.
  - Beat counter is cleared.
- WBURST:
  - bmem_write = 1; bmem_addr and bmem_wdata come from the owner.
  - Each cycle with bmem_ready = 1 is an accepted beat: c{owner}_ready = 1 and the counter increments.
  - The beat that takes the count to BURST_LEN returns to IDLE.
- RISSUE:
  - bmem_read = 1; bmem_addr comes from the owner.
  - On bmem_ready = 1: c{owner}_ready = 1 and the state moves to RWAIT.
- RWAIT:
  - Each bmem_rvalid asserts c{owner}_rvalid and increments the counter.
  - The BURST_LEN-th beat returns to IDLE.
  - An rvalid that arrives while still in RISSUE (same cycle as acceptance) is counted.
- Read-response routing:
  - c0_rvalid and c1_rvalid are never asserted together.
  - bmem_rvalid seen in IDLE or WBURST is dropped and not forwarded.
- The counter wraps to 0 naturally at BURST_LEN.
- The non-owner's cN_ready stays 0; its request stays pending, with no starvation because of round-robin.
- A request deasserted by the owner mid-transaction is ignored; the burst continues until it completes.

## Timing
- Reset values:
  - state = IDLE, owner = 0, last_owner = 1 (so client 0 wins the first tie), counter = 0.
  - bmem_read/write = 0; bmem_addr/wdata = 0.
  - All cN_ready and cN_rvalid = 0.
- Reset behaviour: reset asserted mid-burst forces IDLE immediately. Response beats still arriving after reset releases land in IDLE and are dropped.
- Combinational paths:
  - bmem_* outputs are combinational muxes of the registered owner and state. They are all 0 in IDLE.
  - cN_ready = (state ∈ {WBURST, RISSUE}) & (owner == N) & bmem_ready.
- Request latency: a request first seen in IDLE at cycle t drives bmem_read or bmem_write at t+1 at the earliest.
- Turnaround: at least one IDLE cycle between consecutive transactions.
- Write burst throughput: BURST_LEN cycles minimum when bmem_ready is held high.

## Test plan
- Client 0 write only, bmem_ready held at 1, addr 0x1000, wdata 0xA0..0xA3:
  - bmem_write = 1 for cycles t+1..t+4 with the same 4 beats in order.
  - c0_ready = 1 on each of those cycles.
  - IDLE at t+5.
- Both clients read on the same cycle straight after reset:
  - Client 0 is granted first.
  - After its 4 rvalid beats, client 1 is granted.
  - c1_rvalid stays 0 during client 0's beats.
- Client 1 write in progress with bmem_ready toggling 1,0,1,0,...:
  - Exactly 4 accepted beats.
  - c0 read is held off until IDLE, then granted.
- Reset pulsed low during beat 2 of a read:
  - All outputs go to 0 at once.
  - The remaining 2 rvalid beats are not forwarded to either client.
- Client 0 asserts read and write together:
  - The write burst is issued; bmem_read stays 0.
- Both clients request continuously for 4 transactions:
  - Grants alternate 0,1,0,1.
